// File: rtl/shift_pkg.sv
// Shared definitions for the 4-bit shift register and its word sender:
// shift command encodings on {s1,s0} and the sender state encoding.
package shift_pkg;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit counter for the word sender: synchronous clear, count enable and a
// terminal flag raised while the count points at the last bit of the word.
module shift_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    // count issued bits; clear has priority so an accept always restarts at 0
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)       cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en)    cnt <= cnt + 1'b1;
    end

    assign term = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_word_sender.sv
// Streams a parallel word, one bit per clock, into a downstream shift
// register together with the matching {s1,s0} shift command.
// Optional build macro SHIFT_WORD_SENDER_PARITY_EN adds a one-cycle PARITY
// state after the shift that presents even parity on sr_sin with a hold
// command, delaying done by one cycle.
module shift_word_sender
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             hold,
    output logic             sr_s1,
    output logic             sr_s0,
    output logic             sr_sin,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [1:0]       sel;
    logic [WIDTH-1:0] word;
    logic             dir;
    logic             last_sent;   // all WIDTH commands have been issued
    logic [CNT_W-1:0] cnt;
    logic             term;
    logic             accept;
    logic             step;
    logic [WIDTH-1:0] word_lsb;    // word >> cnt: current bit in position 0
    logic [WIDTH-1:0] word_msb;    // word << cnt: current bit in the top position

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign step     = (state == SHIFT) && !last_sent && !hold;
    assign word_lsb = word >> cnt;
    assign word_msb = word << cnt;
    assign sr_s1    = sel[1];
    assign sr_s0    = sel[0];

    shift_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .clr   (clr),
        .clear (accept),
        .en    (step),
        .cnt   (cnt),
        .term  (term)
    );

    // sender FSM with registered command, serial bit, busy and done
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            sel       <= SEL_HOLD;
            sr_sin    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            word      <= '0;
            dir       <= 1'b0;
            last_sent <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sel <= SEL_HOLD;
                    if (accept) begin
                        word      <= in_data;
                        dir       <= in_dir;
                        last_sent <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_sent) begin
                        // wrap-up edge: command returns to hold; not stallable
                        sel <= SEL_HOLD;
`ifdef SHIFT_WORD_SENDER_PARITY_EN
                        sr_sin <= ^word;
                        state  <= PARITY;
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
`endif
                    end else if (hold) begin
                        sel <= SEL_HOLD;
                    end else begin
                        sel    <= dir ? SEL_RIGHT : SEL_LEFT;
                        sr_sin <= dir ? word_lsb[0] : word_msb[WIDTH-1];
                        if (term) last_sent <= 1'b1;
                    end
                end
                PARITY: begin
                    sel   <= SEL_HOLD;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    sel   <= SEL_HOLD;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_word_sender.sv
// Directed bench for shift_word_sender driving a real 4-bit shift register.
module tb_shift_word_sender;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'b0;
    logic       in_dir = 1'b0;
    logic       hold = 1'b0;
    logic       sr_s1, sr_s0, sr_sin, busy, done;
    logic [3:0] q = 4'b0;
    logic [3:0] load_d = 4'b0;
    int total = 0;
    int bad = 0;

    shift_word_sender #(.WIDTH(4)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dir(in_dir), .hold(hold),
        .sr_s1(sr_s1), .sr_s0(sr_s0), .sr_sin(sr_sin),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // downstream 4-bit universal shift register; serial bit on both r_in and l_in
    always_ff @(posedge clk) begin
        case ({sr_s1, sr_s0})
            SEL_LEFT:  q <= {q[2:0], sr_sin};
            SEL_RIGHT: q <= {sr_sin, q[3:1]};
            SEL_LOAD:  q <= load_d;
            default:   q <= q;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] w;
        total++;
        if ({sr_s1, sr_s0, sr_sin, busy, done} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=00000", {sr_s1, sr_s0, sr_sin, busy, done});
        end
        clr = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        // start a transfer and abort it at cnt=2
        w = 4'b1011;
        in_data = w; in_dir = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++;
        if ({sr_s1, sr_s0, sr_sin, busy} !== 4'b0101) begin
            bad++; $display("FAIL abort_pre got=%b want=0101", {sr_s1, sr_s0, sr_sin, busy});
        end
        clr = 1'b0;
        #1;
        total++;
        if ({sr_s1, sr_s0, sr_sin, busy, done} !== 5'b0) begin
            bad++; $display("FAIL abort_outputs got=%b want=00000", {sr_s1, sr_s0, sr_sin, busy, done});
        end
        tick();
        clr = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_release ready=%b busy=%b want 1 0", in_ready, busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || {sr_s1, sr_s0} !== SEL_HOLD) begin
                bad++; $display("FAIL abort_no_done cyc=%0d done=%b s=%b want 0 00", i, done, {sr_s1, sr_s0});
            end
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] bits;
        bits = 4'b1011;
        in_data = 4'b1011; in_dir = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 4'b0000; in_dir = 1'b1;  // mid-transfer changes must not matter
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL msb_busy busy=%b ready=%b want 1 0", busy, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({sr_s1, sr_s0} !== 2'b01 || sr_sin !== bits[3-i] || done !== 1'b0) begin
                bad++; $display("FAIL msb_bit%0d s=%b sin=%b done=%b want 01 %b 0", i, {sr_s1, sr_s0}, sr_sin, done, bits[3-i]);
            end
        end
`ifdef SHIFT_WORD_SENDER_PARITY_EN
        tick();
`endif
        tick();
        total++;
        if (done !== 1'b1 || {sr_s1, sr_s0} !== 2'b00 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL msb_done done=%b s=%b ready=%b busy=%b want 1 00 1 0", done, {sr_s1, sr_s0}, in_ready, busy);
        end
        total++;
        if (q !== 4'b1011) begin bad++; $display("FAIL msb_q got=%b want=1011", q); end
        tick();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL msb_done_width got=%b want=0", done); end
    endtask

    task automatic test_lsb_first();
        logic [3:0] bits;
        bits = 4'b0110;
        in_data = 4'b0110; in_dir = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({sr_s1, sr_s0} !== 2'b10 || sr_sin !== bits[i]) begin
                bad++; $display("FAIL lsb_bit%0d s=%b sin=%b want 10 %b", i, {sr_s1, sr_s0}, sr_sin, bits[i]);
            end
        end
`ifdef SHIFT_WORD_SENDER_PARITY_EN
        tick();
`endif
        tick();
        total++;
        if (done !== 1'b1 || q !== 4'b0110) begin
            bad++; $display("FAIL lsb_done done=%b q=%b want 1 0110", done, q);
        end
    endtask

    task automatic test_hold();
        // expected per cycle N+1..N+7 (no parity): s, sin, done
        logic [1:0] exp_s   [7];
        logic       exp_sin [7];
        logic       exp_done[7];
        exp_s    = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        exp_sin  = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        exp_done = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        in_data = 4'b1100; in_dir = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            hold = (i == 1 || i == 2);
`ifdef SHIFT_WORD_SENDER_PARITY_EN
            if (i == 6) tick();
`endif
            tick();
            total++;
            if ({sr_s1, sr_s0} !== exp_s[i] || sr_sin !== exp_sin[i] || done !== exp_done[i]) begin
                bad++; $display("FAIL hold_cyc%0d s=%b sin=%b done=%b want %b %b %b",
                                i + 1, {sr_s1, sr_s0}, sr_sin, done, exp_s[i], exp_sin[i], exp_done[i]);
            end
        end
        hold = 1'b0;
        total++;
        if (q !== 4'b1100) begin bad++; $display("FAIL hold_q got=%b want=1100", q); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w1, w2;
        w1 = 4'b1010; w2 = 4'b0101;
        in_data = w1; in_dir = 1'b0; in_valid = 1'b1;
        tick();
        in_data = w2;   // offered while busy: must wait for in_ready
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (sr_sin !== w1[3-i] || in_ready !== 1'b0) begin
                bad++; $display("FAIL b2b_w1_bit%0d sin=%b ready=%b want %b 0", i, sr_sin, in_ready, w1[3-i]);
            end
        end
`ifdef SHIFT_WORD_SENDER_PARITY_EN
        tick();
`endif
        tick();
        total++;
        if (done !== 1'b1 || in_ready !== 1'b1 || q !== w1) begin
            bad++; $display("FAIL b2b_first_done done=%b ready=%b q=%b want 1 1 %b", done, in_ready, q, w1);
        end
        tick();    // second word accepted on the done cycle's closing edge
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_accept busy=%b done=%b want 1 0", busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({sr_s1, sr_s0} !== 2'b01 || sr_sin !== w2[3-i]) begin
                bad++; $display("FAIL b2b_w2_bit%0d s=%b sin=%b want 01 %b", i, {sr_s1, sr_s0}, sr_sin, w2[3-i]);
            end
        end
`ifdef SHIFT_WORD_SENDER_PARITY_EN
        tick();
`endif
        tick();
        total++;
        if (done !== 1'b1 || q !== w2) begin
            bad++; $display("FAIL b2b_second_done done=%b q=%b want 1 %b", done, q, w2);
        end
    endtask

`ifdef SHIFT_WORD_SENDER_PARITY_EN
    task automatic test_parity();
        in_data = 4'b0111; in_dir = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tick();
        total++;
        if ({sr_s1, sr_s0} !== 2'b00 || sr_sin !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL parity_cyc s=%b sin=%b done=%b busy=%b want 00 1 0 1", {sr_s1, sr_s0}, sr_sin, done, busy);
        end
        tick();
        total++;
        if (done !== 1'b1 || q !== 4'b0111) begin
            bad++; $display("FAIL parity_done done=%b q=%b want 1 0111", done, q);
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_hold();
        test_back_to_back();
`ifdef SHIFT_WORD_SENDER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
